// File: rtl/lcd_ctrl.sv
// HD44780 character-LCD sequencer: runs the power-up init ROM, then writes requested
// command/data bytes with setup/enable/hold timing and per-command busy delays.
module lcd_ctrl #(
  parameter int unsigned T_PWRUP_CYC = 750000,
  parameter int unsigned T_SETUP_CYC = 2,
  parameter int unsigned T_EN_CYC    = 12,
  parameter int unsigned T_HOLD_CYC  = 2,
  parameter int unsigned T_INIT1_CYC = 205000,
  parameter int unsigned T_CMD_CYC   = 2000,
  parameter int unsigned T_CLR_CYC   = 82000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  output logic        init_done_o,
  output logic        busy_o,
  output logic [31:0] io_lcd_o
);

  function automatic int unsigned min1(input int unsigned v);
    return (v == 0) ? 32'd1 : v;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // PWRUP also spans the partial cycle in which reset is released, hence the extra count.
  localparam int unsigned PWRUP_LEN = min1(T_PWRUP_CYC) + 1;
  localparam int unsigned SETUP_LEN = min1(T_SETUP_CYC);
  localparam int unsigned EN_LEN    = min1(T_EN_CYC);
  localparam int unsigned HOLD_LEN  = min1(T_HOLD_CYC);
  localparam int unsigned INIT1_LEN = min1(T_INIT1_CYC);
  localparam int unsigned CMD_LEN   = min1(T_CMD_CYC);
  localparam int unsigned CLR_LEN   = min1(T_CLR_CYC);
  localparam int unsigned MAX_LEN   = max2(max2(max2(PWRUP_LEN, SETUP_LEN), max2(EN_LEN, HOLD_LEN)),
                                           max2(max2(INIT1_LEN, CMD_LEN), CLR_LEN));
  localparam int unsigned CW        = $clog2(MAX_LEN + 1);
  localparam logic [2:0]  INIT_LAST = 3'd6;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_LOAD,
    S_SETUP,
    S_ENH,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } state_e;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: return 8'h38;
      3'd4:                   return 8'h0C;
      3'd5:                   return 8'h01;
      default:                return 8'h06;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          req_rs_q, req_rs_d;
  logic [7:0]    req_data_q, req_data_d;
  logic [2:0]    init_idx_q, init_idx_d;
  logic          init_mode_q, init_mode_d;
  logic          init_done_q, init_done_d;
  logic          on_q, on_d;

  int unsigned   cur_len;
  int unsigned   wait_len;
  logic          last_cyc;
  logic          is_clear;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      req_rs_q    <= 1'b0;
      req_data_q  <= 8'h00;
      init_idx_q  <= 3'd0;
      init_mode_q <= 1'b0;
      init_done_q <= 1'b0;
      on_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      req_rs_q    <= req_rs_d;
      req_data_q  <= req_data_d;
      init_idx_q  <= init_idx_d;
      init_mode_q <= init_mode_d;
      init_done_q <= init_done_d;
      on_q        <= on_d;
    end
  end

  // Clear (0x01) and return-home (0x02/0x03) are the slow instructions.
  assign is_clear = !rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'h00);

  always_comb begin
    if (init_mode_q && (init_idx_q == 3'd0)) begin
      wait_len = INIT1_LEN;
    end else if (is_clear) begin
      wait_len = CLR_LEN;
    end else begin
      wait_len = CMD_LEN;
    end
    case (state_q)
      S_PWRUP: cur_len = PWRUP_LEN;
      S_SETUP: cur_len = SETUP_LEN;
      S_ENH:   cur_len = EN_LEN;
      S_HOLD:  cur_len = HOLD_LEN;
      S_WAIT:  cur_len = wait_len;
      default: cur_len = 32'd1;
    endcase
    last_cyc = (32'(cnt_q) + 32'd1) >= cur_len;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    rs_d        = rs_q;
    data_d      = data_q;
    req_rs_d    = req_rs_q;
    req_data_d  = req_data_q;
    init_idx_d  = init_idx_q;
    init_mode_d = init_mode_q;
    init_done_d = init_done_q;
    on_d        = 1'b1;

    case (state_q)
      S_PWRUP: begin
        if (last_cyc) begin
          state_d     = S_LOAD;
          cnt_d       = '0;
          init_idx_d  = 3'd0;
          init_mode_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (init_mode_q) begin
          rs_d   = 1'b0;
          data_d = init_byte(init_idx_q);
        end else begin
          rs_d   = req_rs_q;
          data_d = req_data_q;
        end
        state_d = S_SETUP;
        cnt_d   = '0;
      end
      S_SETUP: begin
        if (last_cyc) begin
          state_d = S_ENH;
          cnt_d   = '0;
        end
      end
      S_ENH: begin
        if (last_cyc) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        if (last_cyc) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (last_cyc) begin
          cnt_d = '0;
          if (init_mode_q && (init_idx_q != INIT_LAST)) begin
            init_idx_d = init_idx_q + 3'd1;
            state_d    = S_LOAD;
          end else begin
            if (init_mode_q) begin
              init_done_d = 1'b1;
            end
            init_mode_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (req_valid_i) begin
          req_rs_d   = req_rs_i;
          req_data_d = req_data_i;
          state_d    = S_LOAD;
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = '0;
      end
    endcase
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign init_done_o = init_done_q;
  assign io_lcd_o    = {on_q, 20'h00000, (state_q == S_ENH), rs_q, 1'b0, data_q};

endmodule
